// File: rtl/reg_bank_20x32.sv
// reg_bank_20x32
//   Thirty-two entry, 20-bit register bank feeding the channel multiplexer.
//   Entry 0 is a constant zero. After reset (or on clr_req) a sweep zeroes one
//   entry per cycle for 32 cycles; the bank is hidden (all outputs zero) and
//   writes are refused while it runs.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   clr_req           re-run the clear sweep (honoured in IDLE only)
//   wr_valid/ready    write handshake; wr_addr/wr_data carry the write
//   rd_addr_a/b       combinational read ports with write-first bypass
//   rd_data_a/b
//   bank_bus          every stored entry, entry i on bank_bus[i], no bypass
//   busy              clear sweep in progress

// One storage entry. Clear wins over write, though the two never coincide
// because writes are only accepted outside the sweep.
module reg_bank_entry #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             we,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // No reset: the sweep is what zeroes the contents.
    always_ff @(posedge clk) begin
        if (clr)
            q <= '0;
        else if (we)
            q <= d;
    end
endmodule

module reg_bank_20x32 #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr_req,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [4:0]                  wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic [4:0]                  rd_addr_a,
    input  logic [4:0]                  rd_addr_b,
    output logic [WIDTH-1:0]            rd_data_a,
    output logic [WIDTH-1:0]            rd_data_b,
    output logic [DEPTH-1:0][WIDTH-1:0] bank_bus,
    output logic                        busy
);
    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] clr_cnt_q, clr_cnt_d;

    logic                        wr_fire;
    logic [DEPTH-1:0]            wr_en;
    logic [DEPTH-1:0]            clr_en;
    logic [DEPTH-1:0][WIDTH-1:0] entries;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                // 5-bit counter wraps to 0 naturally after entry 31.
                clr_cnt_d = clr_cnt_q + 5'd1;
                if (clr_cnt_q == 5'd31)
                    state_d = IDLE;
            end
            IDLE: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    assign busy = (state_q == CLEAR);

    // A write colliding with clr_req or rst is refused, so the requester
    // keeps holding it rather than having it silently lost.
    assign wr_ready = (state_q == IDLE) && !clr_req && !rst;
    assign wr_fire  = wr_valid && wr_ready;

    // ------------------------------------------------------- enable decode
    always_comb begin
        wr_en = '0;
        if (wr_fire)
            wr_en[wr_addr] = 1'b1;
    end

    always_comb begin
        clr_en = '0;
        if (state_q == CLEAR)
            clr_en[clr_cnt_q] = 1'b1;
    end

    // ------------------------------------------------------------ storage
    // Entry 0 has no storage; writes to it complete and are dropped.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        if (i == 0) begin : g_zero
            assign entries[i] = '0;
        end else begin : g_reg
            reg_bank_entry #(.WIDTH(WIDTH)) u_entry (
                .clk (clk),
                .we  (wr_en[i]),
                .clr (clr_en[i]),
                .d   (wr_data),
                .q   (entries[i])
            );
        end
    end

    // --------------------------------------------------------------- reads
    // Bypass only for nonzero addresses so entry 0 always reads zero. During
    // the sweep everything is masked so a half-cleared bank never leaks out.
    always_comb begin
        rd_data_a = entries[rd_addr_a];
        if (wr_fire && (wr_addr == rd_addr_a) && (wr_addr != 5'd0))
            rd_data_a = wr_data;
        if (busy)
            rd_data_a = '0;
    end

    always_comb begin
        rd_data_b = entries[rd_addr_b];
        if (wr_fire && (wr_addr == rd_addr_b) && (wr_addr != 5'd0))
            rd_data_b = wr_data;
        if (busy)
            rd_data_b = '0;
    end

    assign bank_bus = busy ? '0 : entries;

    // At most one entry may be written or cleared in any cycle.
    a_wr_onehot:  assert property (@(posedge clk) $onehot0(wr_en));
    a_clr_onehot: assert property (@(posedge clk) $onehot0(clr_en));

endmodule

// File: tb/tb_reg_bank_20x32.sv
module tb_reg_bank_20x32;
    logic              clk = 1'b0;
    logic              rst, clr_req, wr_valid, wr_ready, busy;
    logic [4:0]        wr_addr, rd_addr_a, rd_addr_b;
    logic [19:0]       wr_data, rd_data_a, rd_data_b;
    logic [31:0][19:0] bank_bus;

    reg_bank_20x32 dut (
        .clk(clk), .rst(rst), .clr_req(clr_req),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .bank_bus(bank_bus), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    endtask

    // ------------------------------------------------ behavioural model
    // The bank is either hidden (sweep running, m_left edges to go) or
    // visible with contents m_mem. A finished sweep leaves every entry zero.
    bit          m_known = 0;
    bit          m_busy  = 0;
    int          m_left  = 0;
    logic [19:0] m_mem [32];

    always @(posedge clk) begin
        if (rst) begin
            m_known <= 1;
            m_busy  <= 1;
            m_left  <= 32;
        end else if (m_known) begin
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 0;
                    for (int i = 0; i < 32; i++) m_mem[i] <= '0;
                end
            end else if (clr_req) begin
                m_busy <= 1;
                m_left <= 32;
            end else if (wr_valid && wr_addr != 0) begin
                m_mem[wr_addr] <= wr_data;
            end
        end
    end

    function automatic logic [19:0] model_rd(input logic [4:0] a, input bit fire);
        if (m_busy || a == 0) return '0;
        if (fire && wr_addr == a) return wr_data;
        return m_mem[a];
    endfunction

    // Compare process: every cycle once the model state is defined.
    always @(negedge clk) begin
        if (m_known) begin
            bit          exp_ready;
            int          bad;
            logic [19:0] exp_e;
            exp_ready = !m_busy && !clr_req && !rst;
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("wr_ready", {31'd0, wr_ready}, {31'd0, exp_ready});
            chk("rd_data_a", {12'd0, rd_data_a}, {12'd0, model_rd(rd_addr_a, exp_ready && wr_valid)});
            chk("rd_data_b", {12'd0, rd_data_b}, {12'd0, model_rd(rd_addr_b, exp_ready && wr_valid)});
            bad = -1;
            for (int i = 31; i >= 0; i--) begin
                exp_e = (m_busy || i == 0) ? 20'd0 : m_mem[i];
                if (bank_bus[i] !== exp_e) bad = i;
            end
            if (bad >= 0) begin
                exp_e = (m_busy || bad == 0) ? 20'd0 : m_mem[bad];
                chk($sformatf("bank_bus[%0d]", bad), {12'd0, bank_bus[bad]}, {12'd0, exp_e});
            end else begin
                chk("bank_bus", 32'd0, 32'd0 + (bad < 0 ? 0 : 1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts negedges with busy=1 and wr_ready=0 over 32 cycles, then expects
    // the bank back in IDLE on the following cycle.
    task automatic sweep_check(input string name);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (busy && !wr_ready) cnt++;
        end
        chk({name, "_busy_cycles"}, cnt, 32);
        @(negedge clk);
        chk({name, "_ready_after"}, {31'd0, wr_ready}, 32'd1);
        chk({name, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1; clr_req = 0; wr_valid = 0; wr_addr = 0; wr_data = 0;
        rd_addr_a = 0; rd_addr_b = 0;

        // Reset and sweep
        tick(); tick();
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd1);
        chk("reset_ready", {31'd0, wr_ready}, 32'd0);
        chk("reset_bus", {31'd0, |bank_bus}, 32'd0);
        tick();
        rst = 0;
        sweep_check("reset");
        chk("sweep_bus_zero", {31'd0, |bank_bus}, 32'd0);

        // Write / readback
        tick();
        wr_valid = 1; wr_addr = 5; wr_data = 20'hABCDE; rd_addr_a = 5;
        @(negedge clk);
        chk("wr5_ready", {31'd0, wr_ready}, 32'd1);
        chk("wr5_bypass", {12'd0, rd_data_a}, 32'hABCDE);
        tick();
        wr_addr = 31; wr_data = 20'h12345; rd_addr_b = 31;
        @(negedge clk);
        chk("wr31_ready", {31'd0, wr_ready}, 32'd1);
        chk("bus5", {12'd0, bank_bus[5]}, 32'hABCDE);
        chk("wr31_bypass", {12'd0, rd_data_b}, 32'h12345);
        tick();
        wr_valid = 0;
        @(negedge clk);
        chk("rd_a5", {12'd0, rd_data_a}, 32'hABCDE);
        chk("rd_b31", {12'd0, rd_data_b}, 32'h12345);
        chk("bus31", {12'd0, bank_bus[31]}, 32'h12345);

        // Entry 0
        tick();
        wr_valid = 1; wr_addr = 0; wr_data = 20'hFFFFF; rd_addr_a = 0;
        @(negedge clk);
        chk("wr0_ready", {31'd0, wr_ready}, 32'd1);
        chk("wr0_rd", {12'd0, rd_data_a}, 32'd0);
        tick();
        wr_valid = 0;
        @(negedge clk);
        chk("bus0", {12'd0, bank_bus[0]}, 32'd0);
        chk("rd0_after", {12'd0, rd_data_a}, 32'd0);

        // Bypass while bank_bus still holds the old value
        tick();
        wr_valid = 1; wr_addr = 9; wr_data = 20'h00777; rd_addr_a = 9;
        @(negedge clk);
        chk("byp9_rd", {12'd0, rd_data_a}, 32'h00777);
        chk("byp9_bus_old", {12'd0, bank_bus[9]}, 32'd0);
        tick();
        wr_valid = 0;
        @(negedge clk);
        chk("bus9", {12'd0, bank_bus[9]}, 32'h00777);

        // clr_req collision
        for (int a = 1; a < 32; a++) begin
            tick();
            wr_valid = 1; wr_addr = 5'(a); wr_data = 20'(a);
        end
        tick();
        wr_valid = 1; wr_addr = 3; wr_data = 20'h55555; clr_req = 1;
        @(negedge clk);
        chk("coll_ready", {31'd0, wr_ready}, 32'd0);
        chk("coll_bus3", {12'd0, bank_bus[3]}, 32'd3);
        tick();
        clr_req = 0; wr_valid = 0;
        sweep_check("clr");
        chk("clr_bus_zero", {31'd0, |bank_bus}, 32'd0);

        // Reset mid-sweep
        tick();
        clr_req = 1;
        tick();
        clr_req = 0;
        repeat (16) tick();
        rst = 1;
        tick();
        rst = 0;
        sweep_check("midrst");

        // Random regression
        for (int n = 0; n < 2000; n++) begin
            tick();
            rst       = ($urandom_range(199) == 0);
            clr_req   = ($urandom_range(99) == 0);
            wr_valid  = $urandom_range(1);
            wr_addr   = 5'($urandom);
            wr_data   = 20'($urandom);
            rd_addr_a = ($urandom_range(3) == 0) ? wr_addr : 5'($urandom);
            rd_addr_b = ($urandom_range(3) == 0) ? rd_addr_a : 5'($urandom);
        end
        tick();
        rst = 0; clr_req = 0; wr_valid = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
